// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter: FSM state encoding, digit geometry, saturation
//               value and the leading-zero blanking helper.
// Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int          MAX_VALUE  = 9999;
  localparam int          BCD_W      = 16;
  localparam int          DIGITS     = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;
  // Digit pattern shown when the input exceeds the displayable range.
  localparam logic [15:0] SAT_DIGITS = 16'h9999;

  // Replace leading zero digits above the ones digit with BLANK_CODE.
  // The ones digit is always shown so a value of zero still displays "0".
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    if (bcd[15:12] == 4'd0) begin
      r[15:12] = BLANK_CODE;
      if (bcd[11:8] == 4'd0) begin
        r[11:8] = BLANK_CODE;
        if (bcd[7:4] == 4'd0) begin
          r[7:4] = BLANK_CODE;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational BCD nibble corrector for shift-and-add-3.
//               A nibble of 5 or more gets +3 so that the following left
//               shift carries correctly into the next decimal digit.
// Ports       : i_nib  in  4  BCD nibble before correction
//               o_nib  out 4  corrected nibble
// Revision    : 1.0  initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // For valid digits (0..9) the sum is at most 12, so 4 bits suffice.
  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3).
//               Latches bin on an accepted start, runs BIN_W iterations and
//               then updates the registered digit outputs together with a
//               one-cycle done pulse. Inputs above MAX_VALUE saturate to 9999
//               with ovf set.
// Config      : BCD_BLANK_LEADING_EN - when defined, leading zero digits above
//               d1 are replaced by BLANK_CODE (4'hF) on done.
// Parameters  : BIN_W      binary input width (legal 4..14)
//               MAX_VALUE  largest displayable value
// Ports       : clk    in   1      system clock, rising edge
//               reset  in   1      asynchronous active-high reset
//               start  in   1      conversion request, sampled in IDLE only
//               bin    in   BIN_W  unsigned value latched with start
//               busy   out  1      conversion in progress
//               done   out  1      one-cycle pulse, results valid from here
//               ovf    out  1      last accepted value exceeded MAX_VALUE
//               d1..d4 out  4      ones, tens, hundreds, thousands digits
// Revision    : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 14,
  parameter int MAX_VALUE = bcd_pkg::MAX_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4
);

  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam int c_sr_w  = BCD_W + BIN_W;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_sr_w-1:0]   r_sr;
  logic [c_sr_w-1:0]   w_sr_cat;
  logic [c_sr_w-1:0]   w_sr_nxt;
  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_raw;
  logic [BCD_W-1:0]    w_fmt;
  logic [BCD_W-1:0]    r_digits;
  logic                r_sat;
  logic                r_ovf;
  logic                w_accept;
  logic                w_last;

  assign w_accept = (r_state == IDLE) && start;
  // The final iteration's result is captured straight into the output
  // registers on the same edge that moves the FSM to FINISH.
  assign w_last   = (r_state == SHIFT) && (r_cnt == c_cnt_w'(1));

  // --------------------------------------------------------------------------
  // Shift datapath: correct every BCD nibble, then shift {bcd, bin} left.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_sr[BIN_W + 4*i +: 4]),
      .o_nib (w_adj[4*i +: 4])
    );
  end

  assign w_sr_cat = {w_adj, r_sr[BIN_W-1:0]};
  // The bit shifted out of the top only matters for out-of-range inputs,
  // which are saturated anyway.
  assign w_sr_nxt = w_sr_cat << 1;
  assign w_raw    = w_sr_nxt[BIN_W +: BCD_W];

`ifdef BCD_BLANK_LEADING_EN
  assign w_fmt = blank_leading(w_raw);
`else
  assign w_fmt = w_raw;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_cnt == c_cnt_w'(1)) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sr  <= {{BCD_W{1'b0}}, bin};
        r_cnt <= c_cnt_w'(BIN_W);
        r_sat <= (32'(bin) > 32'(MAX_VALUE));
      end else if (r_state == SHIFT) begin
        r_sr  <= w_sr_nxt;
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
      if (w_last) begin
        r_digits <= r_sat ? SAT_DIGITS : w_fmt;
        r_ovf    <= r_sat;
      end
    end
  end

  assign ovf = r_ovf;
  assign d1  = r_digits[3:0];
  assign d2  = r_digits[7:4];
  assign d3  = r_digits[11:8];
  assign d4  = r_digits[15:12];

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. Table of directed
//               conversions plus hand-written sequences for ignored starts,
//               asynchronous abort and back-to-back operation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 14;

  logic             clk;
  logic             reset;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       d1, d2, d3, d4;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VALUE(9999)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0] v;
    logic [15:0]      plain;
    logic [15:0]      blank;
    bit               ov;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [15:0] pick(input logic [15:0] plain, input logic [15:0] blank);
`ifdef BCD_BLANK_LEADING_EN
    return blank;
`else
    return plain;
`endif
  endfunction

  function automatic logic [15:0] digits();
    return {d4, d3, d2, d1};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Full conversion: start, latency, busy width, hold of old digits, result.
  task automatic conv(input logic [BIN_W-1:0] v, input logic [15:0] exp_d,
                      input bit exp_ovf, input string name);
    logic [15:0] prev_d;
    logic        prev_o;
    int          lat, busy_cnt;
    bit          hold_bad;
    @(negedge clk);
    check({name, "_idle_before"}, {30'd0, busy, done}, 32'd0);
    prev_d = digits();
    prev_o = ovf;
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0; hold_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      if (digits() !== prev_d || ovf !== prev_o) hold_bad = 1'b1;
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end else begin
      check({name, "_latency"}, lat, BIN_W + 1);
      check({name, "_busy_cycles"}, busy_cnt, BIN_W);
      check({name, "_hold"}, {31'd0, hold_bad}, 32'd0);
      check({name, "_digits"}, {16'd0, digits()}, {16'd0, exp_d});
      check({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    end
  endtask

  initial begin
    int          dones, lat;
    logic [15:0] got_d;

    tbl[0]  = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
    tbl[1]  = '{14'd0,     16'h0000, 16'hFFF0, 1'b0};
    tbl[2]  = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
    tbl[3]  = '{14'd12000, 16'h9999, 16'h9999, 1'b1};
    tbl[4]  = '{14'd7,     16'h0007, 16'hFFF7, 1'b0};
    tbl[5]  = '{14'd10000, 16'h9999, 16'h9999, 1'b1};
    tbl[6]  = '{14'd16383, 16'h9999, 16'h9999, 1'b1};
    tbl[7]  = '{14'd42,    16'h0042, 16'hFF42, 1'b0};
    tbl[8]  = '{14'd1000,  16'h1000, 16'h1000, 1'b0};
    tbl[9]  = '{14'd105,   16'h0105, 16'hF105, 1'b0};
    tbl[10] = '{14'd5000,  16'h5000, 16'h5000, 1'b0};
    tbl[11] = '{14'd9,     16'h0009, 16'hFFF9, 1'b0};
    tbl[12] = '{14'd8765,  16'h8765, 16'h8765, 1'b0};
    tbl[13] = '{14'd2468,  16'h2468, 16'h2468, 1'b0};
    tbl[14] = '{14'd909,   16'h0909, 16'hF909, 1'b0};
    tbl[15] = '{14'd5555,  16'h5555, 16'h5555, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_ovf",    {31'd0, ovf},  32'd0);
    check("reset_digits", {16'd0, digits()}, 32'd0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      conv(tbl[i].v, pick(tbl[i].plain, tbl[i].blank), tbl[i].ov,
           $sformatf("tbl%0d", i));
    end

    // Start mid-conversion and during FINISH must be ignored, not queued.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    dones = 0; lat = 0; got_d = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 6 || k == 16) start = 1'b0;
      if (done) begin
        dones++;
        if (lat == 0) lat = k;
        got_d = digits();
      end
      if (k == 5 || k == 15) begin
        start = 1'b1;
        bin   = 14'd5;
      end
    end
    check("ignore_dones",   dones, 1);
    check("ignore_latency", lat, BIN_W + 1);
    check("ignore_digits",  {16'd0, got_d}, 32'h1234);

    // Asynchronous abort during SHIFT; prior result had ovf=1.
    conv(14'd12000, 16'h9999, 1'b1, "pre_abort");
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_ovf",    {31'd0, ovf},  32'd0);
    check("abort_digits", {16'd0, digits()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);
    conv(14'd88, pick(16'h0088, 16'hFF88), 1'b0, "after_abort");

    // Back-to-back: each start in the cycle right after the previous done.
    conv(14'd1,   pick(16'h0001, 16'hFFF1), 1'b0, "b2b_1");
    conv(14'd10,  pick(16'h0010, 16'hFF10), 1'b0, "b2b_10");
    conv(14'd100, pick(16'h0100, 16'hF100), 1'b0, "b2b_100");
    repeat (5) @(negedge clk);
    check("b2b_final_hold", {16'd0, digits()}, {16'd0, pick(16'h0100, 16'hF100)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
